ps2_host_tx: RTL
================

// Module: ps2_host_tx
// PURPOSE
//  Host-to-device PS/2 transmitter: sends one command byte (e.g. 8'hED set-LEDs, 8'hFF reset) to the keyboard.
//  Sits beside ps2_ver2 (the receiver) on the same ps2_clk/ps2_data pins and drives them open-drain through top-level tristates.
//  Sequence: inhibit the clock, request-to-send, shift the byte LSB-first with odd parity and a stop bit, check the device ACK.
// PARAMETERS
//  INHIBIT_CYCLES  10000      clk cycles ps2_clk is held low before RTS (100 us @ 100 MHz)
//  TIMEOUT_CYCLES  2000000    max clk cycles from clock release to ACK/idle (20 ms @ 100 MHz)
// PORTS
//  clk           in   1  system clock; the only clock
//  rst           in   1  reset; synchronous, active-high
//  ps2_clk       in   1  raw PS/2 clock pin, asynchronous
//  ps2_data      in   1  raw PS/2 data pin, asynchronous
//  tx_data       in   8  byte to send; sampled when tx_start is accepted
//  tx_start      in   1  one-cycle request; accepted only when busy==0
//  ps2_clk_low   out  1  1 = pull ps2_clk low; 0 = release (Hi-Z)
//  ps2_data_low  out  1  1 = pull ps2_data low; 0 = release (Hi-Z)
//  busy          out  1  high from the cycle after accept until done/err
//  done          out  1  one-cycle pulse: byte ACKed and both lines back high
//  err           out  1  one-cycle pulse: NACK or timeout; never coincides with done
// BEHAVIOUR
//  Reset: ps2_clk_low=0, ps2_data_low=0, busy=0, done=0, err=0, FSM=IDLE. Reset mid-frame releases both lines on the next clk edge.
//  Synchroniser: 3-stage shift register on ps2_clk; fall = s[2] & ~s[1]. ps2_data goes through a 2-stage synchroniser.
//  FSM:
//   IDLE    : on tx_start, latch tx_data, shift = {~^tx_data, tx_data}, bitcnt=0, busy<=1 -> INHIBIT.
//   INHIBIT : ps2_clk_low=1 for INHIBIT_CYCLES cycles -> RTS.
//   RTS     : ps2_clk_low=1 and ps2_data_low=1 (start bit) for exactly 1 cycle.
//             Then ps2_clk_low<=0 and the timeout counter starts -> SEND.
//   SEND    : on each fall, ps2_data_low <= ~shift[0], shift >>= 1, bitcnt++.
//             Falls 1..8 present d0..d7, fall 9 presents parity.
//             Fall 10: ps2_data_low<=0 (stop bit released) -> ACK.
//   ACK     : on fall 11, sample synced ps2_data: 0 -> WAIT_IDLE; 1 -> error.
//   WAIT_IDLE: both synced lines high for 1 cycle -> done pulse, busy<=0 -> IDLE.
//  Timeout counter runs in SEND/ACK/WAIT_IDLE. On reaching TIMEOUT_CYCLES-1: err pulse, lines released, busy<=0 -> IDLE.
//  Error (NACK): err pulse, busy<=0, both lines released -> IDLE.
//  tx_start while busy is ignored; it is not queued.
//  Parity is odd: parity bit = ~^tx_data, e.g. 8'hED -> 1, 8'h01 -> 0.
//  Counter widths: $clog2(param+1). bitcnt is 4 bits and saturates at 11.
//  Edge case: a fall in the same cycle as the timeout expiry is ignored, so err wins.
//  Known interaction: the receiver sees the device clocks during a transmit. The top level gates its ready with ~busy.
// STRUCTURE
//  Shared header ps2_defs.vh: command bytes (PS2_CMD_SETLED 8'hED, PS2_CMD_RESET 8'hFF, PS2_CMD_ENABLE 8'hF4), PS2_ACK 8'hFA.
//  FSM state encodings are localparams in this file (3-bit binary).
//  Sub-module ps2_edge_sync: 3-stage synchroniser plus falling-edge pulse. Reused later by the receiver refactor.
//  Top level: ps2_clk = ps2_clk_low ? 1'b0 : 1'bz (same pattern for ps2_data).
// TESTING  (INHIBIT_CYCLES=20, TIMEOUT_CYCLES=5000; device model clocks 40 clk low / 40 high)
//  1 tx_start, tx_data=8'hED -> clk held low 20 cycles; model samples 0,1,0,1,1,0,1,1,1,1(par),1(stop); model ACKs -> done=1 one cycle, err=0.
//  2 tx_data=8'h01 -> model sees parity 0 and stop 1; ACK -> done pulse. Frame error checked by the model = none.
//  3 model leaves data high at clock 11 (NACK) -> err pulse 1 cycle, done stays 0, both *_low=0, busy=0.
//  4 model never clocks after RTS -> err exactly TIMEOUT_CYCLES after clock release; lines released.
//  5 tx_start pulsed again during SEND with 8'h55 -> ignored; the frame still carries 8'hED; a single done pulse.
//  6 rst asserted at bit 4 -> next cycle ps2_clk_low=0, ps2_data_low=0, busy=0. A new tx_start 2 cycles later completes normally.

Source files
------------

// File: rtl/ps2_host_tx_pkg.sv
// Shared constants, FSM encoding and frame helper for the PS/2 host-to-device transmitter.
// Latency: n/a (types only); backpressure: n/a.
package ps2_host_tx_pkg;

  localparam logic [7:0] PS2_CMD_SETLED = 8'hED;
  localparam logic [7:0] PS2_CMD_RESET  = 8'hFF;
  localparam logic [7:0] PS2_CMD_ENABLE = 8'hF4;
  localparam logic [7:0] PS2_ACK        = 8'hFA;

  // bitcnt value when the stop-bit fall arrives, and the saturated value after the ACK fall
  localparam logic [3:0] BIT_STOP = 4'd9;
  localparam logic [3:0] BIT_ACK  = 4'd11;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_INHIBIT   = 3'd1,
    ST_RTS       = 3'd2,
    ST_SEND      = 3'd3,
    ST_ACK       = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } state_t;

  function automatic logic [8:0] frame_word(input logic [7:0] d);
    return {~^d, d};
  endfunction

endpackage

// File: rtl/ps2_host_tx_edge_sync.sv
// Three-flop synchroniser for an asynchronous PS/2 pin with a one-cycle falling-edge pulse.
// Latency: o_fall asserts two clk edges after the pin drops; no backpressure.
module ps2_host_tx_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic i_pin,
  output logic o_level,
  output logic o_fall
);

  logic [2:0] r_sync;

  // Idle-high reset so a released bus never produces a spurious fall
  always_ff @(posedge clk) begin
    if (rst) r_sync <= 3'b111;
    else     r_sync <= {r_sync[1:0], i_pin};
  end

  assign o_level = r_sync[1];
  assign o_fall  = r_sync[2] & ~r_sync[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, shift byte+odd parity+stop, check ACK.
// Latency: INHIBIT_CYCLES+1 before release, then device-paced; tx_start ignored while busy.
module ps2_host_tx
  import ps2_host_tx_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       ps2_clk_low,
  output logic       ps2_data_low,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

  state_t        r_state;
  logic [8:0]    r_shift;
  logic [3:0]    r_bitcnt;
  logic [IW-1:0] r_icnt;
  logic [TW-1:0] r_tcnt;
  logic          r_clk_low;
  logic          r_data_low;
  logic          r_busy;
  logic          r_done;
  logic          r_err;
  logic [1:0]    r_data_sync;

  logic w_clk_level;
  logic w_clk_fall;
  logic w_data_level;
  logic w_timeout;

  ps2_host_tx_edge_sync u_clk_sync (
    .clk     (clk),
    .rst     (rst),
    .i_pin   (ps2_clk),
    .o_level (w_clk_level),
    .o_fall  (w_clk_fall)
  );

  always_ff @(posedge clk) begin
    if (rst) r_data_sync <= 2'b11;
    else     r_data_sync <= {r_data_sync[0], ps2_data};
  end

  assign w_data_level = r_data_sync[1];
  assign w_timeout    = (r_tcnt == TO_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_shift    <= '0;
      r_bitcnt   <= '0;
      r_icnt     <= '0;
      r_tcnt     <= '0;
      r_clk_low  <= 1'b0;
      r_data_low <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (tx_start) begin
            r_shift   <= frame_word(tx_data);
            r_bitcnt  <= '0;
            r_icnt    <= '0;
            r_busy    <= 1'b1;
            r_clk_low <= 1'b1;
            r_state   <= ST_INHIBIT;
          end
        end
        ST_INHIBIT: begin
          if (r_icnt == INH_LAST) begin
            r_data_low <= 1'b1;
            r_state    <= ST_RTS;
          end else begin
            r_icnt <= r_icnt + IW'(1);
          end
        end
        ST_RTS: begin
          r_clk_low <= 1'b0;
          r_tcnt    <= '0;
          r_state   <= ST_SEND;
        end
        ST_SEND, ST_ACK, ST_WAIT_IDLE: begin
          // Expiry is checked first so a coincident fall cannot slip through
          if (w_timeout) begin
            r_err      <= 1'b1;
            r_busy     <= 1'b0;
            r_clk_low  <= 1'b0;
            r_data_low <= 1'b0;
            r_state    <= ST_IDLE;
          end else begin
            r_tcnt <= r_tcnt + TW'(1);
            if (r_state == ST_SEND && w_clk_fall) begin
              r_bitcnt <= r_bitcnt + 4'd1;
              if (r_bitcnt == BIT_STOP) begin
                r_data_low <= 1'b0;
                r_state    <= ST_ACK;
              end else begin
                r_data_low <= ~r_shift[0];
                r_shift    <= {1'b0, r_shift[8:1]};
              end
            end else if (r_state == ST_ACK && w_clk_fall) begin
              r_bitcnt <= BIT_ACK;
              if (!w_data_level) begin
                r_state <= ST_WAIT_IDLE;
              end else begin
                r_err      <= 1'b1;
                r_busy     <= 1'b0;
                r_clk_low  <= 1'b0;
                r_data_low <= 1'b0;
                r_state    <= ST_IDLE;
              end
            end else if (r_state == ST_WAIT_IDLE && w_clk_level && w_data_level) begin
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign ps2_clk_low  = r_clk_low;
  assign ps2_data_low = r_data_low;
  assign busy         = r_busy;
  assign done         = r_done;
  assign err          = r_err;

endmodule
